uart_encoder: RTL
=================

UART_ENCODER -- requirements
Module: uart_encoder

Interface
REQ-001 Parameter TERM_CHAR, default 8'h45 ('E'), is the end-of-word byte appended to every frame.
REQ-002 Parameter SUPPRESS_ZEROS, default 0; when 1, leading zero hex digits are omitted.
REQ-003 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 i_stb  input  1  word request; i_word valid in the same cycle.
REQ-006 i_word  input  34  [33:32] command code, [31:0] data value.
REQ-007 o_busy  output  1  high while a frame is in progress; i_stb is accepted only when low.
REQ-008 o_stb  output  1  byte valid toward the UART transmitter.
REQ-009 o_data  output  8  ASCII byte; stable while o_stb=1 and not yet accepted.
REQ-010 i_tx_busy  input  1  transmitter back-pressure; a byte is accepted on a cycle with o_stb=1 and i_tx_busy=0.
REQ-011 o_drop  output  1  one-cycle pulse when i_stb arrives while o_busy=1.

Function
REQ-012 Frame format: one command letter, hex digits MSB first, TERM_CHAR.
REQ-013 Command letter map: 00->8'h52 'R', 01->8'h57 'W', 10->8'h41 'A', 11->8'h53 'S'.
REQ-014 Hex digit map is lowercase: 0-9 -> 8'h30-8'h39, a-f -> 8'h61-8'h66.
REQ-015 With SUPPRESS_ZEROS=0, exactly 8 digits are emitted (10-byte frame).
REQ-016 With SUPPRESS_ZEROS=1, emission starts at the most significant non-zero nibble; data 0 emits the single digit '0'.
REQ-017 FSM states are IDLE, CMD, HEX and TERM.
REQ-018 IDLE -> CMD: on i_stb=1 in IDLE; i_word is latched and the nibble index is set to 7 (or to the first significant nibble if suppressing).
REQ-019 CMD -> HEX: on byte accept.
REQ-020 HEX: on accept, index 0 -> TERM, otherwise index decrements by 1.
REQ-021 TERM -> IDLE: on accept.
REQ-022 o_stb=1 in CMD, HEX and TERM; 0 in IDLE; o_data is registered.
REQ-023 Latency: i_stb accepted at cycle N -> o_stb=1 with the command letter at N+1.
REQ-024 o_busy=1 from N+1 until the cycle after TERM is accepted, so the minimum gap between frames is one IDLE cycle.
REQ-025 With i_tx_busy held at 0, one byte is accepted per cycle.
REQ-026 Stall: while i_tx_busy=1, state, index, o_stb and o_data hold unchanged.
REQ-027 An i_stb with o_busy=1 is ignored (latched word unchanged) and pulses o_drop at the next cycle.
REQ-028 i_word is sampled only at acceptance; later changes do not affect the frame.

Reset
REQ-029 While rst=0: state=IDLE, o_stb=0, o_data=8'h00, o_busy=0, o_drop=0, latched word=0, index=0.
REQ-030 Reset asserted mid-frame aborts immediately with no further bytes; after release the block is ready for a new word.

Structure
REQ-031 Package uart_enc_pkg holds the state enum, the ASCII constants ('R','W','A','S','0','a') and the command-to-letter function.
REQ-032 One combinational sub-module, nibble2ascii (4-bit in, 8-bit ASCII out), performs the hex conversion; everything else stays in uart_encoder.

Verification
REQ-033 i_word={01,32'h1234abcd}, i_tx_busy=0 -> bytes 57 31 32 33 34 61 62 63 64 45 on 10 consecutive cycles, first at N+1.
REQ-034 Same word, i_tx_busy=1 on alternate cycles -> identical byte sequence, o_data constant during each stall, no byte lost or duplicated.
REQ-035 SUPPRESS_ZEROS=1: {00,32'h0} -> 52 30 45; {10,32'h000000f0} -> 41 66 30 45.
REQ-036 i_stb with {11,32'hffffffff} during an active frame -> o_drop one-cycle pulse, current frame unaltered.
REQ-037 rst=0 after 3 accepted bytes -> o_stb=0 at once; after release, word {00,32'h1} -> 52 30 30 30 30 30 30 30 31 45.
REQ-038 i_stb held high continuously -> successive frames separated by exactly one IDLE cycle with o_busy=0.

Source files
------------

// File: rtl/uart_enc_pkg.sv
// Shared types and ASCII constants for the UART hex-word encoder.
package uart_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_HEX,
        ST_TERM
    } state_e;

    localparam logic [7:0] ASCII_R    = 8'h52;
    localparam logic [7:0] ASCII_W    = 8'h57;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_S    = 8'h53;
    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_A_LC = 8'h61;

    function automatic logic [7:0] cmd_letter(input logic [1:0] cmd);
        logic [7:0] letter;
        case (cmd)
            2'b00:   letter = ASCII_R;
            2'b01:   letter = ASCII_W;
            2'b10:   letter = ASCII_A;
            default: letter = ASCII_S;
        endcase
        return letter;
    endfunction

endpackage

// File: rtl/nibble2ascii.sv
// Converts one 4-bit nibble to its lowercase ASCII hex digit.
module nibble2ascii
    import uart_enc_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_ascii = ASCII_0 + {4'd0, i_nibble};
        end else begin
            o_ascii = ASCII_A_LC + {4'd0, i_nibble} - 8'd10;
        end
    end

endmodule

// File: rtl/uart_encoder.sv
// Serialises a command + 32-bit value into an ASCII frame: letter, hex digits
// (MSB first, optionally without leading zeros) and a terminator byte.
module uart_encoder
    import uart_enc_pkg::*;
#(
    parameter logic [7:0] TERM_CHAR      = 8'h45,
    parameter bit         SUPPRESS_ZEROS = 1'b0
) (
    input  logic        i_clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic [33:0] i_word,
    output logic        o_busy,
    output logic        o_stb,
    output logic [7:0]  o_data,
    input  logic        i_tx_busy,
    output logic        o_drop
);

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        drop_q, drop_d;

    logic [2:0]  first_idx;
    logic [2:0]  nib_sel;
    logic [3:0]  nib;
    logic [7:0]  nib_ascii;
    logic        accept;

    // Highest non-zero nibble of the incoming value; zero maps to index 0.
    always_comb begin
        first_idx = 3'd7;
        if (SUPPRESS_ZEROS) begin
            first_idx = 3'd0;
            for (int i = 0; i < 8; i++) begin
                if (i_word[4*i +: 4] != 4'd0) begin
                    first_idx = 3'(i);
                end
            end
        end
    end

    // The digit loaded into o_data is the one that will be shown next.
    assign nib_sel = (state_q == ST_CMD) ? idx_q : idx_q - 3'd1;
    assign nib     = word_q[{nib_sel, 2'b00} +: 4];

    nibble2ascii u_nibble2ascii (
        .i_nibble (nib),
        .o_ascii  (nib_ascii)
    );

    assign accept = (state_q != ST_IDLE) && !i_tx_busy;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        drop_d  = i_stb && (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (i_stb) begin
                    state_d = ST_CMD;
                    word_d  = i_word[31:0];
                    idx_d   = first_idx;
                    data_d  = cmd_letter(i_word[33:32]);
                end
            end
            ST_CMD: begin
                if (accept) begin
                    state_d = ST_HEX;
                    data_d  = nib_ascii;
                end
            end
            ST_HEX: begin
                if (accept) begin
                    if (idx_q == 3'd0) begin
                        state_d = ST_TERM;
                        data_d  = TERM_CHAR;
                    end else begin
                        idx_d  = idx_q - 3'd1;
                        data_d = nib_ascii;
                    end
                end
            end
            ST_TERM: begin
                if (accept) begin
                    state_d = ST_IDLE;
                    data_d  = 8'h00;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    assign o_busy = (state_q != ST_IDLE);
    assign o_stb  = (state_q != ST_IDLE);
    assign o_data = data_q;
    assign o_drop = drop_q;

endmodule
